// File: rtl/uart_cmd_parser.sv
// Decodes 5-byte SYNC/CMD/ADDR/DATA/CHK frames popped from the UART RX FIFO,
// issues register strobes and returns ACK/NAK/read data through the TX UART.
module uart_cmd_parser #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_fifo_data,
  output logic       rx_fifo_read_enable,
  input  logic       rx_fifo_empty,
  output logic [7:0] tx_uart_data,
  output logic       tx_uart_valid,
  input  logic       tx_uart_busy,
  output logic       start_write_frame,
  output logic       reg_wr_en,
  output logic       reg_rd_en,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wr_data,
  input  logic [7:0] reg_rd_data,
  output logic [7:0] frame_err_count
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CMD_START = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;

  typedef enum logic [3:0] {
    S_HUNT, S_CMD, S_ADDR, S_DATA, S_CHK, S_EXEC, S_RD_WAIT, S_TX_ACK, S_TX_DATA
  } state_t;

  // Each TX byte: issue when idle, one valid cycle, one guard cycle, then wait for idle.
  typedef enum logic [1:0] {TXP_ISSUE, TXP_SENT, TXP_GUARD, TXP_DRAIN} tx_phase_t;

  state_t        r_state;
  tx_phase_t     r_tx_phase;
  logic          r_byte_valid;
  logic [TW-1:0] r_tmo;
  logic [7:0]    r_cmd, r_chk, r_addr_cand, r_data_cand;
  logic [7:0]    r_resp_byte, r_rd_resp, r_tx_data, r_err_cnt;
  logic          r_is_ack, r_tx_valid, r_start, r_wr_en, r_rd_en;
  logic [7:0]    r_reg_addr, r_reg_wr_data;

  logic   w_fetch_state, w_in_frame, w_timeout, w_pop, w_cmd_ok;
  logic [7:0] w_tx_byte;
  state_t w_tx_next;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign w_in_frame    = (r_state == S_CMD) || (r_state == S_ADDR) ||
                         (r_state == S_DATA) || (r_state == S_CHK);
  assign w_fetch_state = w_in_frame || (r_state == S_HUNT);
  assign w_timeout     = w_in_frame && !r_byte_valid && (r_tmo == TMO_LAST);
  assign w_cmd_ok      = (r_cmd == CMD_START) || (r_cmd == CMD_WRITE) || (r_cmd == CMD_READ);
  assign w_tx_byte     = (r_state == S_TX_DATA) ? r_rd_resp : r_resp_byte;
  assign w_tx_next     = ((r_state == S_TX_ACK) && r_is_ack && (r_cmd == CMD_READ)) ?
                         S_TX_DATA : S_HUNT;

  // Pop is combinational so a byte can be fetched every second cycle; the cycle
  // carrying byte_valid is the one where the previous read is still outstanding.
  assign w_pop = !rst && w_fetch_state && !rx_fifo_empty && !r_byte_valid && !w_timeout;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every branch
    // below sees the values from before this edge regardless of statement order.
    if (rst) begin
      r_state       <= S_HUNT;
      r_tx_phase    <= TXP_ISSUE;
      r_byte_valid  <= 1'b0;
      r_tmo         <= '0;
      r_cmd         <= '0;
      r_chk         <= '0;
      r_addr_cand   <= '0;
      r_data_cand   <= '0;
      r_resp_byte   <= '0;
      r_rd_resp     <= '0;
      r_tx_data     <= '0;
      r_err_cnt     <= '0;
      r_is_ack      <= 1'b0;
      r_tx_valid    <= 1'b0;
      r_start       <= 1'b0;
      r_wr_en       <= 1'b0;
      r_rd_en       <= 1'b0;
      r_reg_addr    <= '0;
      r_reg_wr_data <= '0;
    end else begin
      r_byte_valid <= w_pop;
      r_tx_valid   <= 1'b0;
      r_start      <= 1'b0;
      r_wr_en      <= 1'b0;
      r_rd_en      <= 1'b0;

      if (!w_in_frame || r_byte_valid) r_tmo <= '0;
      else                             r_tmo <= r_tmo + 1'b1;

      if (w_timeout) begin
        r_state   <= S_HUNT;
        r_err_cnt <= sat_inc(r_err_cnt);
      end else begin
        case (r_state)
          S_HUNT:
            if (r_byte_valid && (rx_fifo_data == SYNC_BYTE)) r_state <= S_CMD;
          S_CMD:
            if (r_byte_valid) begin
              r_cmd   <= rx_fifo_data;
              r_chk   <= rx_fifo_data;
              r_state <= S_ADDR;
            end
          S_ADDR:
            if (r_byte_valid) begin
              r_addr_cand <= rx_fifo_data;
              r_chk       <= r_chk ^ rx_fifo_data;
              r_state     <= S_DATA;
            end
          S_DATA:
            if (r_byte_valid) begin
              r_data_cand <= rx_fifo_data;
              r_chk       <= r_chk ^ rx_fifo_data;
              r_state     <= S_CHK;
            end
          S_CHK:
            if (r_byte_valid) begin
              if ((rx_fifo_data == r_chk) && w_cmd_ok) begin
                // Strobes and register outputs become visible during EXEC.
                r_reg_addr    <= r_addr_cand;
                r_reg_wr_data <= r_data_cand;
                r_start       <= (r_cmd == CMD_START);
                r_wr_en       <= (r_cmd == CMD_WRITE);
                r_rd_en       <= (r_cmd == CMD_READ);
                r_state       <= S_EXEC;
              end else begin
                r_err_cnt   <= sat_inc(r_err_cnt);
                r_resp_byte <= NAK_BYTE;
                r_is_ack    <= 1'b0;
                r_state     <= S_TX_ACK;
              end
            end
          S_EXEC:
            if (r_cmd == CMD_READ) begin
              r_state <= S_RD_WAIT;
            end else begin
              r_resp_byte <= ACK_BYTE;
              r_is_ack    <= 1'b1;
              r_state     <= S_TX_ACK;
            end
          S_RD_WAIT: begin
            r_rd_resp   <= reg_rd_data;
            r_resp_byte <= ACK_BYTE;
            r_is_ack    <= 1'b1;
            r_state     <= S_TX_ACK;
          end
          S_TX_ACK, S_TX_DATA:
            case (r_tx_phase)
              TXP_ISSUE:
                if (!tx_uart_busy) begin
                  r_tx_valid <= 1'b1;
                  r_tx_data  <= w_tx_byte;
                  r_tx_phase <= TXP_SENT;
                end
              TXP_SENT:  r_tx_phase <= TXP_GUARD;
              TXP_GUARD: r_tx_phase <= TXP_DRAIN;
              TXP_DRAIN:
                if (!tx_uart_busy) begin
                  r_tx_phase <= TXP_ISSUE;
                  r_state    <= w_tx_next;
                end
              default: r_tx_phase <= TXP_ISSUE;
            endcase
          default: r_state <= S_HUNT;
        endcase
      end
    end
  end

  assign rx_fifo_read_enable = w_pop;
  assign tx_uart_data        = r_tx_data;
  assign tx_uart_valid       = r_tx_valid;
  assign start_write_frame   = r_start;
  assign reg_wr_en           = r_wr_en;
  assign reg_rd_en           = r_rd_en;
  assign reg_addr            = r_reg_addr;
  assign reg_wr_data         = r_reg_wr_data;
  assign frame_err_count     = r_err_cnt;

endmodule
